// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared constants and the pipeline shadow-stage record.
// Revision 1.0 - initial release
`default_nettype none

package hazard_scoreboard_pkg;

    localparam int REG_W          = 5;
    localparam int NREG           = 32;
    localparam int MC_LAT_DEFAULT = 4;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             load;
    } shadow_t;

    // x0 writes are architecturally discarded, so they never create a hazard.
    function automatic logic counts_write(shadow_t s);
        return s.v & s.wr & (s.rd != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_mc_tracker.sv
// hazard_scoreboard_mc_tracker: busy/countdown/destination of the single in-flight MUL/DIV op.
// Revision 1.0 - initial release
`default_nettype none

module hazard_scoreboard_mc_tracker #(
    parameter int REG_W  = hazard_scoreboard_pkg::REG_W,
    parameter int MC_LAT = hazard_scoreboard_pkg::MC_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  logic             flush_i,
    input  logic [REG_W-1:0] rd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [REG_W-1:0] rd_o
);
    import hazard_scoreboard_pkg::*;

    localparam int CW = $clog2(MC_LAT + 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [REG_W-1:0] rd_q, rd_d;

    assign done_o = busy_q & (cnt_q == CW'(1));
    assign busy_o = busy_q;
    assign rd_o   = rd_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rd_d   = rd_q;
        if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            // A full count means the op is still in EX and can be squashed.
            if (done_o || (flush_i && cnt_q == CW'(MC_LAT))) begin
                busy_d = 1'b0;
            end
        end
        if (issue_i) begin
            busy_d = 1'b1;
            cnt_d  = CW'(MC_LAT);
            rd_d   = rd_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rd_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes and raises load-use / multi-cycle stalls.
// Revision 1.0 - initial release
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_W  = hazard_scoreboard_pkg::REG_W,
    parameter int NREG   = hazard_scoreboard_pkg::NREG,
    parameter int MC_LAT = hazard_scoreboard_pkg::MC_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_adv,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             id_is_mc,
    output logic             id_ready,
    output logic             stall_lu,
    output logic             stall_mc,
    output logic             bubble_ex,
    output logic [NREG-1:0]  pending,
    output logic             mc_done,
    output logic [REG_W-1:0] mc_rd
);
    import hazard_scoreboard_pkg::*;

    shadow_t ex_q, mem_q, wb_q, ex_d;
    logic    issue, mc_busy, mc_rd_nz;

    assign issue    = id_valid & id_ready & pipe_adv;
    assign mc_rd_nz = (mc_rd != '0);

    assign stall_lu = ex_q.v & ex_q.load & ex_q.wr & (ex_q.rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                       (id_use_rs2 & (id_rs2 == ex_q.rd)));

    assign stall_mc = mc_busy & ~mc_done & id_valid &
                      ((mc_rd_nz & ((id_use_rs1   & (id_rs1 == mc_rd)) |
                                    (id_use_rs2   & (id_rs2 == mc_rd)) |
                                    (id_reg_write & (id_rd  == mc_rd)))) |
                       id_is_mc);

    assign id_ready  = ~stall_lu & ~stall_mc & ~flush;
    assign bubble_ex = pipe_adv & id_valid & ~id_ready;

    // MC ops ride the shadows as non-writers; the tracker alone owns their rd.
    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.v    = 1'b1;
            ex_d.rd   = id_rd;
            ex_d.wr   = id_reg_write & ~id_is_mc;
            ex_d.load = id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (pipe_adv) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NREG; r++) begin
            pending[r] = (counts_write(ex_q)  && ex_q.rd  == REG_W'(r)) ||
                         (counts_write(mem_q) && mem_q.rd == REG_W'(r)) ||
                         (counts_write(wb_q)  && wb_q.rd  == REG_W'(r)) ||
                         (mc_busy && mc_rd == REG_W'(r));
        end
    end

    hazard_scoreboard_mc_tracker #(
        .REG_W  (REG_W),
        .MC_LAT (MC_LAT)
    ) u_mc_tracker (
        .clk     (clk),
        .rst     (rst),
        .issue_i (issue & id_is_mc),
        .flush_i (flush),
        .rd_i    (id_rd),
        .busy_o  (mc_busy),
        .done_o  (mc_done),
        .rd_o    (mc_rd)
    );

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the forwarding mux-select logic: tracks every in-flight register write from issue (ID→EX) to retirement (WB).
- Decides when an ID-stage instruction cannot be satisfied by bypassing and must stall:
  - load-use hazards;
  - operands or destination owned by a multi-cycle unit (MUL/DIV) still in flight.
- Sits beside the decode stage, drives the ID/EX enable and bubble insertion, and exports a pending-write mask.

Parameters:
REG_W, 5, register index width
NREG, 32, architectural registers (x0 hard-wired zero)
MC_LAT, 4, multi-cycle unit latency in cycles (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pipe_adv  in  1  whole pipeline advances this cycle (0 = memory stall, all shadows hold)
flush  in  1  squash instruction in ID and the one just entering EX
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_W  source 1 index
id_rs2  in  REG_W  source 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_W  destination index
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_is_mc  in  1  instruction uses the multi-cycle unit
id_ready  out  1  ID may issue (= ~stall_lu & ~stall_mc & ~flush)
stall_lu  out  1  load-use stall active
stall_mc  out  1  multi-cycle stall active
bubble_ex  out  1  insert NOP into EX this cycle
pending  out  NREG  bit r set while register r has an outstanding write
mc_done  out  1  multi-cycle result valid this cycle
mc_rd  out  REG_W  destination of the multi-cycle op

Behaviour:
- Reset (async, rst=1):
  - ex/mem/wb shadow valids = 0; mc_busy = 0; mc_cnt = 0; mc_rd = 0.
  - Outputs: id_ready = 1 (if flush=0), stall_lu = 0, stall_mc = 0, bubble_ex = 0, pending = 0, mc_done = 0.
- Shadows: three stages (EX, MEM, WB). Each holds {v, rd, wr, load}. WB retires on the next advance.
- issue = id_valid & id_ready & pipe_adv.
- On a clk edge with pipe_adv=1:
  - EX ← issue ? ID fields : bubble (v=0).
  - MEM ← EX; WB ← MEM.
  - pipe_adv=0: all shadows hold.
- A write counts only if v & wr & rd != 0. An instruction issued with id_is_mc does not enter the shadows as a writer; the MC tracker owns its rd.
- stall_lu is combinational: EX.v & EX.load & EX.wr & EX.rd != 0, and either (id_use_rs1 & id_rs1 == EX.rd) or (id_use_rs2 & id_rs2 == EX.rd). Gives exactly one bubble, after which forwarding from MEM/WB covers the hazard.
- stall_mc is combinational: mc_busy & ~mc_done, and id_valid, and any of:
  - id_use_rs1 & rs1 == mc_rd (RAW);
  - id_use_rs2 & rs2 == mc_rd (RAW);
  - id_reg_write & rd == mc_rd (WAW);
  - id_is_mc (structural).
- When mc_rd == 0, only the structural term applies.
- bubble_ex = pipe_adv & id_valid & ~id_ready.
- MC tracker:
  - Issue with id_is_mc: mc_busy ← 1, mc_rd ← id_rd, mc_cnt ← MC_LAT.
  - While busy, mc_cnt decrements every clk, regardless of pipe_adv.
  - mc_done = mc_busy & (mc_cnt == 1).
  - On the edge where mc_done=1: mc_busy ← 0.
  - The result is forwardable during the mc_done cycle.
- flush:
  - Suppresses issue this cycle, and EX ← bubble on this edge.
  - If mc_busy & mc_cnt == MC_LAT (MC op still in EX), mc_busy ← 0 (op cancelled).
  - Older MEM/WB instructions are unaffected.
- pending[r] = OR over the EX/MEM/WB shadows with a counting write to r, OR (mc_busy & mc_rd == r). pending[0] is always 0.
- Simultaneous events:
  - stall_lu and stall_mc may both assert.
  - mc_done together with a new id_is_mc: stall_mc=0, so a back-to-back issue is allowed and reloads the tracker on the same edge.

Decomposition:
- Shared package holds:
  - REG_W and NREG constants;
  - the shadow-stage record {v, rd, wr, load};
  - MC_LAT default.
- One natural sub-module: mc_tracker (busy/cnt/rd, cancel, done).

Test Plan:
- Reset release: pending=0, id_ready=1, mc_done=0 → all values hold while id_valid=0.
- lw x5, then add x6,x5,x1 in the next cycle → stall_lu=1 and bubble_ex=1 for exactly 1 cycle; add issues on the following cycle; pending[5]=1 for 3 advancing cycles.
- div x7 (MC_LAT=4), then add x8,x7,x2 → stall_mc=1 for 3 cycles; mc_done=1 on cycle 4 with mc_rd=7; add issues that cycle.
- Back-to-back div x9, div x10 → second div stalls until the mc_done cycle of the first, then issues; mc_rd=10.
- lw x0 followed by a consumer of x0 → no stall; pending[0]=0 throughout.
- div x11 issued, flush on the next cycle → mc_busy clears, pending[11]=0, no mc_done. Separately, pipe_adv=0 for 2 cycles with lw x3 in EX → shadows hold, stall_lu stays asserted, and the MC counter keeps decrementing.
